// File: rtl/sha256_nonce_scheduler.sv
// Nonce-search job controller feeding a fixed-latency, non-stallable SHA-256 pipeline.
// Latency: one block per cycle while issuing; done_o pulses n + PIPE_LATENCY + 1 cycles after start_i.
// Backpressure: none; the pipeline cannot stall, so issue never pauses once a job is running.
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   start_i, abort_i                   job start (IDLE only) / early stop while issuing
//   template_i, nonce_start_i,
//   nonce_last_i, num_zero_i           job configuration (latched on start)
//   pipe_d_o, pipe_num_zero_o          block and difficulty towards the pipeline
//   pipe_matched_i, pipe_hash_i,
//   pipe_original_i                    pipeline results, PIPE_LATENCY cycles after issue
//   busy_o, done_o, found_o, aborted_o job status
//   found_nonce_o, found_hash_o        first qualified match of the job
//   issued_o                           blocks issued this job
module sha256_nonce_scheduler #(
    parameter int PIPE_LATENCY = 90
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [479:0] template_i,
    input  logic [31:0]  nonce_start_i,
    input  logic [31:0]  nonce_last_i,
    input  logic [7:0]   num_zero_i,
    output logic [511:0] pipe_d_o,
    output logic [7:0]   pipe_num_zero_o,
    input  logic         pipe_matched_i,
    input  logic [255:0] pipe_hash_i,
    input  logic [511:0] pipe_original_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         found_o,
    output logic         aborted_o,
    output logic [31:0]  found_nonce_o,
    output logic [255:0] found_hash_o,
    output logic [31:0]  issued_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [PIPE_LATENCY-1:0] vld_sr;
    logic [31:0]             nonce_cnt;
    logic [31:0]             nonce_last_q;
    logic [479:0]            template_q;

    logic qual_match;
    logic drain_tail;
    logic start_job;
    logic issue;
    logic capture;
    logic set_abort;
    logic arm_done;
    logic finish;

    // Only the nonce field of the echoed plaintext is reported.
    logic unused_original;
    assign unused_original = ^pipe_original_i[479:0];

    // vld_sr[PIPE_LATENCY-1] is set exactly when the pipeline output belongs to a
    // block issued by this job, so leftovers from reset or earlier jobs never count.
    assign qual_match = pipe_matched_i & vld_sr[PIPE_LATENCY-1];

    // Only the oldest slot (if any) is still in flight: the register empties at the
    // coming edge, which lets done_o be registered yet coincide with an empty vld_sr.
    assign drain_tail = (vld_sr[PIPE_LATENCY-2:0] == '0);

    always_comb begin
        state_d   = state_q;
        start_job = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        set_abort = 1'b0;
        arm_done  = 1'b0;
        finish    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    start_job = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // found_o is always clear while issuing, so any qualified match is the first.
                capture = qual_match;
                if (abort_i) begin
                    set_abort = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    issue = 1'b1;
                    if (qual_match || (nonce_cnt == nonce_last_q)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                capture = qual_match & ~found_o;
                if (done_o) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else if (drain_tail) begin
                    arm_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            vld_sr          <= '0;
            nonce_cnt       <= '0;
            nonce_last_q    <= '0;
            template_q      <= '0;
            pipe_d_o        <= '0;
            pipe_num_zero_o <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            found_o         <= 1'b0;
            aborted_o       <= 1'b0;
            found_nonce_o   <= '0;
            found_hash_o    <= '0;
            issued_o        <= '0;
        end else begin
            state_q <= state_d;
            vld_sr  <= {vld_sr[PIPE_LATENCY-2:0], issue};
            done_o  <= arm_done;

            if (start_job) begin
                template_q      <= template_i;
                nonce_last_q    <= nonce_last_i;
                pipe_num_zero_o <= num_zero_i;
                nonce_cnt       <= nonce_start_i;
                found_o         <= 1'b0;
                aborted_o       <= 1'b0;
                found_nonce_o   <= '0;
                found_hash_o    <= '0;
                issued_o        <= '0;
                busy_o          <= 1'b1;
            end

            if (issue) begin
                pipe_d_o  <= {nonce_cnt, template_q};
                nonce_cnt <= nonce_cnt + 32'd1;
                issued_o  <= issued_o + 32'd1;
            end

            if (capture) begin
                found_o       <= 1'b1;
                found_nonce_o <= pipe_original_i[511:480];
                found_hash_o  <= pipe_hash_i;
            end

            if (set_abort) begin
                aborted_o <= 1'b1;
            end

            if (finish) begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule
